// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types: frame geometry and the framer FSM state encoding.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2State_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes a raw PS/2 line, debounces it with a run-length filter and
// emits a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic lineRaw,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          lvl_p2;
    logic [CW-1:0] runCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            lvl_p2  <= 1'b1;
            runCnt  <= '0;
            fall    <= 1'b0;
        end else begin
            // stage p0/p1: metastability synchronizer
            sync_p0 <= lineRaw;
            sync_p1 <= sync_p0;
            // stage p2: level flips only after FILTER_LEN disagreeing samples
            fall    <= 1'b0;
            if (sync_p1 == lvl_p2) begin
                runCnt <= '0;
            end else if (runCnt == CW'(FILTER_LEN - 1)) begin
                lvl_p2 <= sync_p1;
                runCnt <= '0;
                fall   <= lvl_p2;
            end else begin
                runCnt <= runCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receive framer (start, 8 data LSB first, odd parity, stop).
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx_framer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_c,
    input  logic                     ps2_d,
    output logic [PS2_DATA_BITS-1:0] rx_byte,
    output logic                     rx_done,
    output logic                     rx_err,
    output logic                     rx_busy
);

    localparam int BW = $clog2(PS2_DATA_BITS + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    function automatic logic [BW-1:0] satInc(input logic [BW-1:0] v);
        return (v >= BW'(PS2_DATA_BITS)) ? v : v + 1'b1;
    endfunction

    logic                     fall;
    logic                     dSync_p0;
    logic                     dSync_p1;
    ps2State_t                state, stateNext;
    logic [BW-1:0]            bitCnt, bitCntNext;
    logic [PS2_DATA_BITS-1:0] shiftReg, shiftNext;
    logic                     parityBit, parityNext;
    logic [TW-1:0]            toCnt, toCntNext;
    logic [PS2_DATA_BITS-1:0] byteNext;
    logic                     doneNext, errNext;
    logic                     toTerm;
    logic                     parityGood;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
        .clk     (clk),
        .rst     (rst),
        .lineRaw (ps2_c),
        .fall    (fall)
    );

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parityGood = ^{shiftReg, parityBit};
`else
    // parity is still evaluated but can never veto a frame
    assign parityGood = (^{shiftReg, parityBit}) | 1'b1;
`endif

    assign toTerm  = (toCnt == TW'(TIMEOUT_CYC - 1));
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dSync_p0  <= 1'b1;
            dSync_p1  <= 1'b1;
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
            rx_byte   <= '0;
            rx_done   <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            dSync_p0  <= ps2_d;
            dSync_p1  <= dSync_p0;
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            toCnt     <= toCntNext;
            rx_byte   <= byteNext;
            rx_done   <= doneNext;
            rx_err    <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        byteNext   = rx_byte;
        doneNext   = 1'b0;
        errNext    = 1'b0;

        if (fall || state == IDLE || toTerm) toCntNext = '0;
        else                                 toCntNext = toCnt + 1'b1;

        case (state)
            IDLE: if (fall && !dSync_p1) begin
                stateNext  = DATA;
                bitCntNext = '0;
                shiftNext  = '0;
            end
            DATA: if (fall) begin
                shiftNext  = {dSync_p1, shiftReg[PS2_DATA_BITS-1:1]};
                bitCntNext = satInc(bitCnt);
                if (bitCnt == BW'(PS2_DATA_BITS - 1)) stateNext = PARITY;
            end
            PARITY: if (fall) begin
                parityNext = dSync_p1;
                stateNext  = STOP;
            end
            STOP: if (fall) begin
                stateNext = IDLE;
                if (dSync_p1 && parityGood) begin
                    byteNext = shiftReg;
                    doneNext = 1'b1;
                end else begin
                    errNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // an edge arriving on the terminal count keeps the frame alive
        if (state != IDLE && !fall && toTerm) begin
            stateNext = IDLE;
            errNext   = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Randomized scoreboard bench for ps2_rx_framer with a frame-level reference model.
module tb_ps2_rx_framer;
    import ps2_pkg::*;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_c;
    logic       ps2_d;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;

    typedef struct {
        logic       isErr;
        logic [7:0] byteVal;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] modelByte;
    int         checks = 0;
    int         errors = 0;
    bit         stimDone = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_framer #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_c   (ps2_c),
        .ps2_d   (ps2_d),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .rx_err  (rx_err),
        .rx_busy (rx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [PS2_FRAME_BITS-1:0] mkFrame(input logic [7:0] d, input logic p,
                                                          input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Frame outcome from the protocol rules: odd ones count over data+parity, stop must be 1.
    task automatic expectFrame(input logic [7:0] d, input logic p, input logic s);
        int  ones;
        bit  ok;
        ones = $countones(d) + int'(p);
`ifdef PS2_RX_PARITY_CHECK_EN
        ok = s && (ones % 2 == 1);
`else
        ok = s;
`endif
        if (ok) begin
            modelByte = d;
            expQ.push_back('{1'b0, d});
        end else begin
            expQ.push_back('{1'b1, modelByte});
        end
    endtask

    task automatic sendBits(input logic [PS2_FRAME_BITS-1:0] fr, input int nFalls, input int hp);
        for (int i = 0; i < nFalls; i++) begin
            ps2_d = fr[i];
            repeat (hp) @(posedge clk);
            ps2_c = 1'b0;
            repeat (hp) @(posedge clk);
            ps2_c = 1'b1;
        end
        repeat (hp) @(posedge clk);
        ps2_d = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic p, input logic s, input int hp);
        expectFrame(d, p, s);
        sendBits(mkFrame(d, p, s), PS2_FRAME_BITS, hp);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", expQ.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic monitor();
        logic prevD = 1'b0;
        logic prevE = 1'b0;
        exp_t e;
        while (!stimDone) begin
            @(negedge clk);
            if (rx_done || rx_err) begin
                chk("pulse_excl", {31'b0, rx_done & rx_err}, 0);
                chk("pulse_width", {31'b0, (prevD & rx_done) | (prevE & rx_err)}, 0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b byte=0x%0h, expected no pulse",
                             rx_done, rx_err, rx_byte);
                end else begin
                    e = expQ.pop_front();
                    chk("pulse_kind_err", {31'b0, rx_err}, {31'b0, e.isErr});
                    chk("rx_byte", {24'b0, rx_byte}, {24'b0, e.byteVal});
                end
            end
            prevD = rx_done;
            prevE = rx_err;
        end
    endtask

    task automatic stimulus();
        logic [7:0] d;
        logic       p, s;
        int         hp;

        sendFrame(8'hFA, 1'b1, 1'b1, 20);
        waitDrain(2000);
        sendFrame(8'h08, 1'b1, 1'b1, 20);
        waitDrain(2000);
        sendFrame(8'h08, 1'b0, 1'b0, 20);
        waitDrain(2000);
        chk("busy_after_stop_err", {31'b0, rx_busy}, 0);

        // abandoned frame: start plus four data bits, then the clock stops
        expQ.push_back('{1'b1, modelByte});
        sendBits(mkFrame(8'h5A, 1'b1, 1'b1), 5, 20);
        chk("busy_open_frame", {31'b0, rx_busy}, 1);
        repeat (TIMEOUT_CYC + 10) @(posedge clk);
        waitDrain(2000);
        chk("busy_after_timeout", {31'b0, rx_busy}, 0);
        sendFrame(8'hAA, 1'b1, 1'b1, 20);
        waitDrain(2000);

        // short clock glitch with data low must not look like a start bit
        ps2_d = 1'b0;
        repeat (5) @(posedge clk);
        ps2_c = 1'b0;
        repeat (FILTER_LEN - 1) @(posedge clk);
        ps2_c = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("busy_glitch", {31'b0, rx_busy}, 0);
        end
        ps2_d = 1'b1;
        repeat (20) @(posedge clk);

        // reset in the middle of a frame (after data bit 5)
        sendBits(mkFrame(8'hC3, 1'b1, 1'b1), 6, 20);
        chk("busy_before_reset", {31'b0, rx_busy}, 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mid_byte", {24'b0, rx_byte}, 0);
        chk("reset_mid_busy", {31'b0, rx_busy}, 0);
        chk("reset_mid_done", {31'b0, rx_done}, 0);
        chk("reset_mid_err", {31'b0, rx_err}, 0);
        modelByte = 8'h00;
        @(posedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        chk("busy_after_reset", {31'b0, rx_busy}, 0);
        sendFrame(8'h3C, 1'b1, 1'b1, 20);
        waitDrain(2000);

        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            hp = $urandom_range(12, 40);
            p  = ~(^d);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s  = ($urandom_range(0, 7) != 0);
            sendFrame(d, p, s, hp);
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        waitDrain(4000);
        chk("busy_end", {31'b0, rx_busy}, 0);
        stimDone = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        ps2_c     = 1'b1;
        ps2_d     = 1'b1;
        modelByte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_byte", {24'b0, rx_byte}, 0);
        chk("reset_done", {31'b0, rx_done}, 0);
        chk("reset_err", {31'b0, rx_err}, 0);
        chk("reset_busy", {31'b0, rx_busy}, 0);
        @(posedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        fork
            monitor();
            stimulus();
        join

        chk("queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "time limit");
    end

endmodule
